// File: rtl/spi_reg_slave_pkg.sv
// Shared definitions for the SPI register slave: frame geometry, ID register, FSM encoding.
package spi_reg_slave_pkg;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned CMD_LEN   = 8;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_AW    = 3;
  localparam int unsigned NUM_REGS  = 7;

  localparam logic [DATA_W-1:0] ID_VALUE = 8'hA5;
  localparam logic [REG_AW-1:0] ID_ADDR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // Command byte: R/W flag (1 = read) followed by the 7-bit address.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  // True when the address maps onto the 3-bit register window.
  function automatic logic addr_in_bank(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:REG_AW] == (ADDR_W-REG_AW)'(0);
  endfunction

  // True when a write to this address lands in a read/write register.
  function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
    return addr_in_bank(addr) && (addr[REG_AW-1:0] != ID_ADDR);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous SPI input.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic din,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   fill_q;

  // Synchronizer chain and previous-value flop; both restart from the idle level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{rst_val}};
      prev_q <= rst_val;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Edges stay masked until the chain holds real input, so a line that is
  // already away from its idle level at reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = fill_q[STAGES] &  q & ~prev_q;
  assign fall_c = fill_q[STAGES] & ~q &  prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI slave exposing a small register bank through 16-bit R/W frames, oversampled by clk.
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  CTRL_RST    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CKP,
  input  logic       CPH,
  input  logic       SCK,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  output logic [7:0] ctrl_out,
  output logic       wr_stb,
  output logic [2:0] wr_addr,
  output logic       frame_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic sck_q, sck_rise_c, sck_fall_c;
  logic ss_q, ss_rise_c, ss_fall_c;
  logic mosi_q, mosi_rise_c, mosi_fall_c;
  logic unused_sync_c;

  logic              sample_edge_c, shift_edge_c;
  logic [DATA_W-1:0] rx_next_c;
  cmd_t              cmd_c;
  logic [DATA_W-1:0] rd_data_c;

  logic clear_c, sample_c, cmd_done_c, write_c, abort_c, shift_c;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk    (clk),
    .rst    (rst),
    .rst_val(CKP),
    .din    (SCK),
    .q      (sck_q),
    .rise_c (sck_rise_c),
    .fall_c (sck_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk    (clk),
    .rst    (rst),
    .rst_val(1'b1),
    .din    (SS),
    .q      (ss_q),
    .rise_c (ss_rise_c),
    .fall_c (ss_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk    (clk),
    .rst    (rst),
    .rst_val(1'b0),
    .din    (MOSI),
    .q      (mosi_q),
    .rise_c (mosi_rise_c),
    .fall_c (mosi_fall_c)
  );

  // Abort uses the SS level rather than its edge so a rise coinciding with a sample is not lost.
  assign unused_sync_c = ^{sck_q, ss_rise_c, mosi_rise_c, mosi_fall_c};

  // Sample on the rising SCK edge when CKP matches CPH, otherwise on the falling edge.
  assign sample_edge_c = (CKP == CPH) ? sck_rise_c : sck_fall_c;
  assign shift_edge_c  = (CKP == CPH) ? sck_fall_c : sck_rise_c;

  assign rx_next_c = {rx_q[DATA_W-2:0], mosi_q};
  assign cmd_c     = cmd_t'(rx_next_c);

  // Read mux for the command arriving this cycle.
  always_comb begin
    rd_data_c = '0;
    if (addr_in_bank(cmd_c.addr)) begin
      if (cmd_c.addr[REG_AW-1:0] == ID_ADDR) begin
        rd_data_c = ID_VALUE;
      end else begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (cmd_c.addr[REG_AW-1:0] == REG_AW'(i)) begin
            rd_data_c = regs_q[i];
          end
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control strobes; a sample edge wins over an SS rise in the same cycle.
  always_comb begin
    state_d    = state_q;
    clear_c    = 1'b0;
    sample_c   = 1'b0;
    cmd_done_c = 1'b0;
    write_c    = 1'b0;
    abort_c    = 1'b0;
    shift_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall_c) begin
          clear_c = 1'b1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (sample_edge_c) begin
          sample_c = 1'b1;
          if (bit_cnt_q == CNT_W'(CMD_LEN - 1)) begin
            cmd_done_c = 1'b1;
            state_d    = DATA;
          end
        end else if (ss_q) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (sample_edge_c) begin
          sample_c = 1'b1;
          if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            write_c = ~cmd_q.rw & addr_writable(cmd_q.addr);
            state_d = DONE;
          end
        end else if (ss_q) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end else if (shift_edge_c && cmd_q.rw) begin
          shift_c = 1'b1;
        end
      end
      DONE: begin
        if (ss_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter, receive shifter, command latch and transmit shifter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_q     <= '0;
      MISO      <= 1'b0;
    end else begin
      if (clear_c) begin
        bit_cnt_q <= '0;
        rx_q      <= '0;
      end else if (sample_c) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        rx_q      <= rx_next_c;
      end
      if (cmd_done_c) begin
        cmd_q <= cmd_c;
        tx_q  <= cmd_c.rw ? rd_data_c : '0;
      end
      if (shift_c) begin
        MISO <= tx_q[DATA_W-1];
        tx_q <= {tx_q[DATA_W-2:0], 1'b0};
      end else if (state_d != DATA) begin
        MISO <= 1'b0;
      end
    end
  end

  // Register bank and write/abort strobes; ctrl_out follows register 0 directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? CTRL_RST : '0;
      end
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= write_c;
      frame_err <= abort_c;
      if (write_c) begin
        wr_addr <= cmd_q.addr[REG_AW-1:0];
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (write_c && (cmd_q.addr[REG_AW-1:0] == REG_AW'(i))) begin
          regs_q[i] <= rx_next_c;
        end
      end
    end
  end

  assign ctrl_out = regs_q[0];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed plus random bench for spi_reg_slave with a behavioural SPI master and register model.
module tb_spi_reg_slave;

  localparam logic [7:0] CTRL_RST_V = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       CKP, CPH, SCK, SS, MOSI;
  logic       MISO;
  logic [7:0] ctrl_out;
  logic       wr_stb;
  logic [2:0] wr_addr;
  logic       frame_err;

  spi_reg_slave #(.SYNC_STAGES(3), .CTRL_RST(CTRL_RST_V)) dut (
    .clk      (clk),
    .rst      (rst),
    .CKP      (CKP),
    .CPH      (CPH),
    .SCK      (SCK),
    .SS       (SS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .ctrl_out (ctrl_out),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Pulse monitor, sampled on the falling clk edge.
  int         stb_cnt  = 0;
  int         ferr_cnt = 0;
  logic [2:0] last_wr_addr = 3'd0;
  logic [7:0] ctrl_prev = 8'h00;
  logic [7:0] ctrl_at_stb = 8'h00;
  logic [7:0] ctrl_before_stb = 8'h00;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt++;
      last_wr_addr    = wr_addr;
      ctrl_at_stb     = ctrl_out;
      ctrl_before_stb = ctrl_prev;
    end
    if (frame_err) ferr_cnt++;
    ctrl_prev = ctrl_out;
  end

  // Reference register model: 0-6 read/write, 7 is the ID, anything above reads zero.
  logic [7:0] mregs [7];

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a > 7'd7) return 8'h00;
    if (a == 7'd7) return 8'hA5;
    return mregs[a[2:0]];
  endfunction

  task automatic m_write(input logic [6:0] a, input logic [7:0] d);
    if (a < 7'd7) mregs[a[2:0]] = d;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 7; i++) mregs[i] = 8'h00;
    mregs[0] = CTRL_RST_V;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Half an SCK period: 6 clk cycles, so SCK runs at clk/12.
  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  // SPI master: ncyc SCK cycles, MSB first; bits past 16 carry random MOSI.
  task automatic xfer(input logic [1:0] mode, input logic [15:0] word, input int ncyc,
                      input bit raise_ss, output logic [15:0] rx, output logic [3:0] tail);
    logic b;
    rx   = '0;
    tail = '0;
    CKP  = mode[1];
    CPH  = mode[0];
    SCK  = mode[1];
    MOSI = 1'b0;
    half();
    half();
    SS = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      b = (i < 16) ? word[15-i] : 1'($urandom);
      if (!CPH) MOSI = b;
      half();
      if (!CPH) begin
        if (i < 16) rx[15-i] = MISO; else if (i < 20) tail[i-16] = MISO;
      end
      SCK = ~CKP;
      if (CPH) MOSI = b;
      half();
      if (CPH) begin
        if (i < 16) rx[15-i] = MISO; else if (i < 20) tail[i-16] = MISO;
      end
      SCK = CKP;
    end
    half();
    if (raise_ss) begin
      SS = 1'b1;
      half();
      half();
    end
  endtask

  task automatic do_write(input logic [1:0] mode, input logic [6:0] a, input logic [7:0] d,
                          output logic [15:0] rx);
    logic [3:0] t;
    xfer(mode, {1'b0, a, d}, 16, 1'b1, rx, t);
    m_write(a, d);
  endtask

  task automatic do_read(input logic [1:0] mode, input logic [6:0] a, output logic [7:0] d,
                         output logic [7:0] hi);
    logic [15:0] rx;
    logic [3:0]  t;
    xfer(mode, {1'b1, a, 8'($urandom)}, 16, 1'b1, rx, t);
    d  = rx[7:0];
    hi = rx[15:8];
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    logic [3:0]  tail;
    logic [7:0]  d, hi;
    logic [6:0]  a;
    logic [1:0]  mode;
    int          s0, f0, r;

    rst = 1'b0; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; SS = 1'b1; MOSI = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("rst_miso", 32'(MISO), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_ctrl_out", 32'(ctrl_out), 32'(CTRL_RST_V));
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Write 3C to addr 2 and read it back in every mode.
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      s0 = stb_cnt;
      do_write(mode, 7'd2, 8'h3C, rx);
      chk("w2_stb_count", 32'(stb_cnt - s0), 32'd1);
      chk("w2_wr_addr", 32'(last_wr_addr), 32'd2);
      chk("w2_miso_zero", 32'(rx), 32'd0);
      do_read(mode, 7'd2, d, hi);
      chk("r2_data", 32'(d), 32'h3C);
      chk("r2_cmd_miso_zero", 32'(hi), 32'd0);
      do_write(mode, 7'd2, 8'(m), rx);
    end

    // Register 0 drives ctrl_out in the same cycle as wr_stb.
    s0 = stb_cnt;
    do_write(2'd1, 7'd0, 8'h81, rx);
    chk("w0_stb_count", 32'(stb_cnt - s0), 32'd1);
    chk("w0_ctrl_at_stb", 32'(ctrl_at_stb), 32'h81);
    chk("w0_ctrl_before_stb", 32'(ctrl_before_stb), 32'(CTRL_RST_V));
    chk("w0_ctrl_out", 32'(ctrl_out), 32'h81);

    // ID register is read-only.
    do_read(2'd0, 7'd7, d, hi);
    chk("r7_id", 32'(d), 32'hA5);
    do_write(2'd3, 7'd7, 8'hFF, rx);
    do_read(2'd2, 7'd7, d, hi);
    chk("r7_after_write", 32'(d), 32'hA5);

    // Out-of-bank address reads zero and writes nowhere.
    do_read(2'd0, 7'h40, d, hi);
    chk("r40_zero", 32'(d), 32'h00);
    do_write(2'd0, 7'h40, 8'h77, rx);
    for (int i = 0; i < 7; i++) begin
      do_read(2'd0, 7'(i), d, hi);
      chk("bank_after_w40", 32'(d), 32'(m_read(7'(i))));
    end

    // Write aborted after 11 SCK cycles.
    s0 = stb_cnt;
    f0 = ferr_cnt;
    xfer(2'd0, {1'b0, 7'd3, 8'hEE}, 11, 1'b1, rx, tail);
    chk("abort_ferr_count", 32'(ferr_cnt - f0), 32'd1);
    chk("abort_stb_count", 32'(stb_cnt - s0), 32'd0);
    do_read(2'd1, 7'd3, d, hi);
    chk("abort_reg3", 32'(d), 32'(m_read(7'd3)));

    // Reset in the middle of a read, SS still low across release.
    s0 = stb_cnt;
    f0 = ferr_cnt;
    xfer(2'd1, {1'b1, 7'd0, 8'h00}, 10, 1'b0, rx, tail);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_miso", 32'(MISO), 32'd0);
    rst = 1'b1;
    m_reset();
    repeat (20) @(negedge clk);
    SS = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_ferr_count", 32'(ferr_cnt - f0), 32'd0);
    chk("midrst_stb_count", 32'(stb_cnt - s0), 32'd0);
    do_read(2'd0, 7'd0, d, hi);
    chk("midrst_reg0", 32'(d), 32'(CTRL_RST_V));

    // 20 SCK cycles in one read frame: extra edges ignored, MISO low.
    do_write(2'd2, 7'd1, 8'h96, rx);
    s0 = stb_cnt;
    f0 = ferr_cnt;
    xfer(2'd2, {1'b1, 7'd1, 8'h00}, 20, 1'b1, rx, tail);
    chk("long_data", 32'(rx[7:0]), 32'h96);
    chk("long_tail_zero", 32'(tail), 32'd0);
    chk("long_stb_count", 32'(stb_cnt - s0), 32'd0);
    chk("long_ferr_count", 32'(ferr_cnt - f0), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      mode = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      a = (r < 8) ? 7'(r) : 7'($urandom_range(8, 127));
      if ($urandom_range(0, 1) == 1) begin
        s0 = stb_cnt;
        do_read(mode, a, d, hi);
        chk("rand_read", 32'(d), 32'(m_read(a)));
        chk("rand_read_stb", 32'(stb_cnt - s0), 32'd0);
      end else begin
        d = 8'($urandom);
        s0 = stb_cnt;
        do_write(mode, a, d, rx);
        if (a < 7'd7) begin
          chk("rand_write_stb", 32'(stb_cnt - s0), 32'd1);
          chk("rand_write_addr", 32'(last_wr_addr), 32'(a[2:0]));
        end
        chk("rand_write_miso", 32'(rx), 32'd0);
      end
    end
    for (int i = 0; i < 8; i++) begin
      do_read(2'(i % 4), 7'(i), d, hi);
      chk("final_bank", 32'(d), 32'(m_read(7'(i))));
    end
    chk("final_ctrl_out", 32'(ctrl_out), 32'(mregs[0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
